// File: rtl/rv_test_pkg.sv
// rtl/rv_test_pkg.sv - shared types and constants for the riscv-tests end-of-test monitor
package rv_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_e;

    // riscv-tests leaves gp==1 on pass, otherwise (test_num << 1) | 1
    localparam int unsigned GP_PASS_VALUE = 1;

    localparam logic [31:0] DEFAULT_END_PC      = 32'h0000_0044;
    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and enable
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - end-of-test verdict detector for riscv-tests on the Core
// Optional tohost store path enabled by RISCV_TEST_MONITOR_TOHOST_EN.
module riscv_test_monitor
    import rv_test_pkg::*;
#(
    parameter int unsigned      XLEN           = 32,
    parameter logic [XLEN-1:0]  END_PC         = XLEN'(DEFAULT_END_PC),
    parameter int unsigned      STABLE_CYCLES  = 2,
    parameter int unsigned      TIMEOUT_CYCLES = 5000,
    parameter int unsigned      CNT_W          = 32
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
    ,
    parameter logic [XLEN-1:0]  TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic [XLEN-1:0]  gp_value,
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
    input  logic             store_valid,
    input  logic [XLEN-1:0]  store_addr,
    input  logic [XLEN-1:0]  store_data,
`endif
    output logic             done,
    output logic             passed,
    output logic             failed,
    output logic             timed_out,
    output logic [XLEN-2:0]  fail_test_num,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    localparam logic [3:0]       STABLE_LAST  = 4'(STABLE_CYCLES - 1);
    localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_e      state_q, state_d;
    logic [3:0]      stable_q, stable_d;
    logic            passed_d, failed_d, timed_out_d;
    logic [XLEN-2:0] fail_num_d;

    logic in_run;
    logic end_pc_retire;
    logic end_hit;
    logic timeout_hit;

    assign in_run        = (state_q == ST_RUN);
    assign end_pc_retire = retire_valid && (retire_pc == END_PC);
    // the retire that completes the stable run fires this cycle, not one later
    assign end_hit       = end_pc_retire && (stable_q == STABLE_LAST);
    assign timeout_hit   = TIMEOUT_EN && (cycle_count == TIMEOUT_LAST);

`ifdef RISCV_TEST_MONITOR_TOHOST_EN
    logic tohost_hit;
    assign tohost_hit = store_valid && (store_addr == TOHOST_ADDR) && store_data[0];
`endif

    assign done = passed | failed;

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .enable (in_run),
        .count  (cycle_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_instret_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .enable (in_run && retire_valid),
        .count  (instret_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            stable_q      <= '0;
            passed        <= 1'b0;
            failed        <= 1'b0;
            timed_out     <= 1'b0;
            fail_test_num <= '0;
        end else begin
            state_q       <= state_d;
            stable_q      <= stable_d;
            passed        <= passed_d;
            failed        <= failed_d;
            timed_out     <= timed_out_d;
            fail_test_num <= fail_num_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stable_d    = stable_q;
        passed_d    = passed;
        failed_d    = failed;
        timed_out_d = timed_out;
        fail_num_d  = fail_test_num;

        if (start) begin
            state_d     = ST_RUN;
            stable_d    = '0;
            passed_d    = 1'b0;
            failed_d    = 1'b0;
            timed_out_d = 1'b0;
            fail_num_d  = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (retire_valid) begin
                        stable_d = end_pc_retire ? (stable_q + 4'd1) : 4'd0;
                    end
                    if (end_hit) begin
                        state_d = ST_CHECK;
                    end else if (timeout_hit) begin
                        state_d     = ST_DONE;
                        failed_d    = 1'b1;
                        timed_out_d = 1'b1;
                        fail_num_d  = '0;
                    end
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
                    // a tohost write is an explicit verdict and overrides both other paths
                    if (tohost_hit) begin
                        state_d     = ST_DONE;
                        timed_out_d = 1'b0;
                        if (store_data == XLEN'(GP_PASS_VALUE)) begin
                            passed_d   = 1'b1;
                            failed_d   = 1'b0;
                            fail_num_d = '0;
                        end else begin
                            passed_d   = 1'b0;
                            failed_d   = 1'b1;
                            fail_num_d = store_data[XLEN-1:1];
                        end
                    end
`endif
                end
                ST_CHECK: begin
                    state_d = ST_DONE;
                    if (gp_value == XLEN'(GP_PASS_VALUE)) begin
                        passed_d = 1'b1;
                    end else begin
                        failed_d   = 1'b1;
                        fail_num_d = gp_value[XLEN-1:1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb/tb_riscv_test_monitor.sv - directed self-checking bench for riscv_test_monitor
module tb_riscv_test_monitor;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             retire_valid;
    logic [XLEN-1:0]  retire_pc;
    logic [XLEN-1:0]  gp_value;
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
    logic             store_valid;
    logic [XLEN-1:0]  store_addr;
    logic [XLEN-1:0]  store_data;
`endif
    logic             done;
    logic             passed;
    logic             failed;
    logic             timed_out;
    logic [XLEN-2:0]  fail_test_num;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_test_monitor #(
        .XLEN           (XLEN),
        .END_PC         (32'h44),
        .STABLE_CYCLES  (2),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .retire_valid  (retire_valid),
        .retire_pc     (retire_pc),
        .gp_value      (gp_value),
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
        .store_valid   (store_valid),
        .store_addr    (store_addr),
        .store_data    (store_data),
`endif
        .done          (done),
        .passed        (passed),
        .failed        (failed),
        .timed_out     (timed_out),
        .fail_test_num (fail_test_num),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    typedef struct {
        int          n_fill;
        logic [31:0] gp;
        logic        exp_passed;
        logic        exp_failed;
        logic [30:0] exp_num;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start        = 1'b1;
        retire_valid = 1'b0;
        step();
        start        = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc);
        retire_valid = 1'b1;
        retire_pc    = pc;
        step();
    endtask

    task automatic idle_cycle();
        retire_valid = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".done"},      done,          0);
        check({tag, ".passed"},    passed,        0);
        check({tag, ".failed"},    failed,        0);
        check({tag, ".timed_out"}, timed_out,     0);
        check({tag, ".fail_num"},  fail_test_num, 0);
        check({tag, ".cycles"},    cycle_count,   0);
        check({tag, ".instret"},   instret_count, 0);
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        retire_valid = 1'b0;
        retire_pc    = '0;
        gp_value     = '0;
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
        store_valid  = 1'b0;
        store_addr   = '0;
        store_data   = '0;
`endif
        vecs[0] = '{10, 32'd1,          1'b1, 1'b0, 31'd0};
        vecs[1] = '{10, 32'd7,          1'b0, 1'b1, 31'd3};
        vecs[2] = '{3,  32'd0,          1'b0, 1'b1, 31'd0};
        vecs[3] = '{0,  32'hFFFF_FFFF,  1'b0, 1'b1, 31'h7FFF_FFFF};
        vecs[4] = '{5,  32'd2,          1'b0, 1'b1, 31'd1};
        vecs[5] = '{0,  32'd3,          1'b0, 1'b1, 31'd1};

        step();
        step();
        check_all_zero("reset");
        rst = 1'b1;
        step();
        check_all_zero("idle");

        // end-PC verdicts, gp sampled in CHECK
        for (int v = 0; v < 6; v++) begin
            gp_value = vecs[v].gp;
            do_start();
            check($sformatf("v%0d.start_cycles", v), cycle_count, 0);
            check($sformatf("v%0d.start_done", v), done, 0);
            for (int i = 0; i < vecs[v].n_fill; i++) retire(32'(4 * i));
            retire(32'h44);
            retire(32'h44);
            check($sformatf("v%0d.check_done", v), done, 0);
            idle_cycle();
            check($sformatf("v%0d.done", v), done, 1);
            check($sformatf("v%0d.passed", v), passed, vecs[v].exp_passed);
            check($sformatf("v%0d.failed", v), failed, vecs[v].exp_failed);
            check($sformatf("v%0d.timed_out", v), timed_out, 0);
            check($sformatf("v%0d.fail_num", v), fail_test_num, vecs[v].exp_num);
            check($sformatf("v%0d.instret", v), instret_count, vecs[v].n_fill + 2);
            check($sformatf("v%0d.cycles", v), cycle_count, vecs[v].n_fill + 2);
            for (int i = 0; i < 3; i++) retire(32'h44);
            check($sformatf("v%0d.frozen_cycles", v), cycle_count, vecs[v].n_fill + 2);
            check($sformatf("v%0d.frozen_instret", v), instret_count, vecs[v].n_fill + 2);
            check($sformatf("v%0d.held_done", v), done, 1);
        end

        // timeout at cycle 20
        gp_value = 32'd1;
        do_start();
        check("to.rearm_done", done, 0);
        for (int i = 0; i < 19; i++) retire(32'h0);
        check("to.pre_done", done, 0);
        check("to.pre_cycles", cycle_count, 19);
        retire(32'h0);
        check("to.done", done, 1);
        check("to.failed", failed, 1);
        check("to.passed", passed, 0);
        check("to.timed_out", timed_out, 1);
        check("to.fail_num", fail_test_num, 0);
        check("to.cycles", cycle_count, 20);
        check("to.instret", instret_count, 20);
        idle_cycle();
        idle_cycle();
        check("to.frozen_cycles", cycle_count, 20);

        // end-PC and timeout in the same cycle: end-PC wins
        gp_value = 32'd1;
        do_start();
        for (int i = 0; i < 18; i++) retire(32'h0);
        retire(32'h44);
        retire(32'h44);
        check("tie.in_check_done", done, 0);
        check("tie.cycles", cycle_count, 20);
        idle_cycle();
        check("tie.passed", passed, 1);
        check("tie.timed_out", timed_out, 0);

        // interrupted stable run; idle cycles keep the stable count
        gp_value = 32'd1;
        do_start();
        retire(32'h44);
        retire(32'h48);
        retire(32'h44);
        idle_cycle();
        idle_cycle();
        idle_cycle();
        check("stable.no_verdict", done, 0);
        retire(32'h44);
        idle_cycle();
        check("stable.verdict", passed, 1);

        // start mid-RUN beats a coincident end-PC retire and clears the stable count
        do_start();
        retire(32'h20);
        retire(32'h44);
        start        = 1'b1;
        retire_valid = 1'b1;
        retire_pc    = 32'h44;
        step();
        start        = 1'b0;
        check("restart.cycles", cycle_count, 0);
        check("restart.instret", instret_count, 0);
        retire(32'h44);
        idle_cycle();
        check("restart.no_verdict", done, 0);
        retire(32'h44);
        idle_cycle();
        check("restart.verdict", passed, 1);

        // asynchronous reset mid-RUN
        do_start();
        for (int i = 0; i < 5; i++) retire(32'(4 * i));
        check("midrst.cycles_before", cycle_count, 5);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst.async");
        step();
        rst = 1'b1;
        retire(32'h0);
        check("midrst.idle_cycles", cycle_count, 0);
        do_start();
        retire(32'h0);
        retire(32'h4);
        retire(32'h8);
        check("midrst.cycles_after", cycle_count, 3);
        check("midrst.instret_after", instret_count, 3);
        check("midrst.done_after", done, 0);

`ifdef RISCV_TEST_MONITOR_TOHOST_EN
        // tohost store beats a coincident end-PC completion
        gp_value = 32'd1;
        do_start();
        retire(32'h44);
        store_valid = 1'b1;
        store_addr  = 32'h1000;
        store_data  = 32'h5;
        retire(32'h44);
        store_valid = 1'b0;
        check("tohost.fail_done", done, 1);
        check("tohost.failed", failed, 1);
        check("tohost.fail_num", fail_test_num, 2);
        check("tohost.passed", passed, 0);
        do_start();
        store_valid = 1'b1;
        store_data  = 32'h4;
        retire(32'h0);
        check("tohost.even_ignored", done, 0);
        store_data  = 32'h1;
        retire(32'h0);
        store_valid = 1'b0;
        check("tohost.passed", passed, 1);
        check("tohost.pass_num", fail_test_num, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
Synthesizable end-of-test detector for riscv-tests runs on the Core, replacing hard-coded per-test PC/register checks in benches. Watches the retire stream and the gp (x3) value, detects the end-of-test PC, and latches a verdict: pass, fail with test number, or timeout. It also counts cycles and retired instructions. It instantiates beside Core in every rv32 test top, and the bench reads `done`/`passed` instead of probing core internals.

Parameters:
XLEN, 32, data/address width of the observed core
END_PC, 32'h44, PC that marks the riscv-tests pass/fail trap loop
STABLE_CYCLES, 2, consecutive retires at END_PC required before the verdict is taken (range 1..15)
TIMEOUT_CYCLES, 5000, cycles after start with no verdict before timeout (0 disables)
CNT_W, 32, width of the cycle and instret counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms the monitor and clears counters/verdict
retire_valid  in  1  an instruction retires this cycle
retire_pc  in  XLEN  PC of the retiring instruction
gp_value  in  XLEN  current architectural x3 (gp)
done  out  1  verdict latched (sticky until start or reset)
passed  out  1  done with gp==1
failed  out  1  done with gp!=1, or timeout
timed_out  out  1  failure was a timeout
fail_test_num  out  XLEN-1  gp>>1 at the verdict; 0 on pass or timeout
cycle_count  out  CNT_W  cycles spent in RUN, saturating
instret_count  out  CNT_W  retires counted in RUN, saturating

Behaviour:
- Reset (rst=0, async): state=IDLE; every output is 0; the stable counter is 0.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE: start=1 goes to RUN next cycle and zeroes both counters.
- RUN:
  - cycle_count increments every cycle.
  - instret_count increments on retire_valid.
  - A retire with retire_pc==END_PC increments the stable counter.
  - A retire at any other PC clears the stable counter.
  - A cycle without retire leaves the stable counter unchanged.
  - When the stable counter reaches STABLE_CYCLES, the next state is CHECK.
- CHECK: lasts one cycle and samples gp_value.
  - gp==1: passed=1.
  - Otherwise: failed=1 and fail_test_num=gp[XLEN-1:1].
  - Next state is DONE and done=1. Outputs are registered, so done rises 1 cycle after CHECK is entered.
- Timeout: TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 while in RUN:
  - Sets failed=1, timed_out=1 and fail_test_num=0, and goes to DONE.
  - If the end-PC condition fires in the same cycle, the end-PC condition wins and the state goes to CHECK.
- DONE: all outputs hold and counters freeze. start=1 re-arms: outputs clear and state goes to RUN.
- start while in RUN or CHECK: restarts. Counters and verdict clear and state stays/returns to RUN; the start takes priority over every other event that cycle.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-run returns to IDLE immediately. No verdict is produced.
- passed and failed are never both 1. done=1 iff passed|failed.

Optional Feature:
RISCV_TEST_MONITOR_TOHOST_EN
- With the macro: adds ports store_valid (in, 1), store_addr (in, XLEN), store_data (in, XLEN), plus parameter TOHOST_ADDR (default 32'h1000).
  - In RUN, a store to TOHOST_ADDR with store_data[0]=1 gives an immediate verdict and takes priority over the END_PC path.
  - store_data==1 means pass.
  - Otherwise it is a fail with fail_test_num=store_data>>1.
- Without the macro: no such ports; only the END_PC/gp path exists.

Decomposition:
- Shared package rv_test_pkg holds:
  - the monitor state enum (IDLE/RUN/CHECK/DONE);
  - the GP_PASS_VALUE=1 constant;
  - the default END_PC constant;
  - the default TOHOST_ADDR constant.
- One sub-module: sat_counter (CNT_W, enable, clear, saturating), instantiated twice for the cycle and instret counters.

Test Plan:
1. start, then 10 retires at PC 0x0..0x24, then 2 retires at 0x44 with gp=1 -> done=1 and passed=1 in the CHECK+1 cycle; instret_count=12; fail_test_num=0.
2. Same sequence with gp=7 -> failed=1, fail_test_num=3, timed_out=0.
3. TIMEOUT_CYCLES=20, start, retires never reach 0x44 -> at cycle 20: done=1, failed=1, timed_out=1, cycle_count=20.
4. Retires 0x44, 0x48, 0x44 with STABLE_CYCLES=2 -> no verdict, because the stable counter is reset by 0x48.
5. Reset pulled low mid-RUN after 5 cycles, then released and start issued -> all outputs 0 during reset; counters restart from 0.
6. With RISCV_TEST_MONITOR_TOHOST_EN: a store of 0x5 to 0x1000 in RUN -> failed=1 and fail_test_num=2 on the next cycle; a store of 0x1 -> passed=1.
